alu_seq: RTL and testbench

Parametrised, handshaked successor to the 64-bit combinational `alu`. It uses the same `fs` function-select encoding and adds three things: a registered result, a valid/ready flow control on input and output, and an iterative multi-cycle shifter that does a configurable number of bits per cycle. It also adds an arithmetic-shift-right mode. It sits between the register-file read stage and writeback, and its registered `status` feeds the flag register.

---
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and an iterative shifter that
// moves up to SHIFT_STEP bits per cycle; status = {V, C, N, Z}.
module alu_seq #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [4:0]       fs,
  input  logic             c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       status,
  output logic             busy
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP = SHIFT_STEP[SHW:0];

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10} shkind_t;

  state_t           state_q, state_d;
  shkind_t          kind_q, kind_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_c, b_c, res, sh_res;
  logic [WIDTH:0]   sum, sh_l, sh_r, sh_a;
  logic [SHW-1:0]   n, rem_nx;
  logic [SHW:0]     k;
  logic             res_c, res_v, sh_c, accept, is_shift;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == SHIFT);
  assign out       = out_q;
  assign status    = status_q;
  assign out_valid = out_valid_q;

  always_comb begin
    a_c      = fs[1] ? ~dataA : dataA;
    b_c      = fs[0] ? ~dataB : dataB;
    n        = dataB[SHW-1:0];
    is_shift = fs[4] && (fs[3:2] != 2'b11);
    sum      = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, c0};
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (fs[4:2])
      3'b000: res = a_c & b_c;
      3'b001: res = a_c | b_c;
      3'b010: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (res[WIDTH-1] != a_c[WIDTH-1]);
      end
      3'b011: res = a_c ^ b_c;
      3'b100, 3'b101, 3'b110: res = a_c;  // zero-distance shift
      default: res = '0;
    endcase
  end

  // One extra bit on the exit side of each shift catches the last bit shifted out.
  always_comb begin
    k      = ({1'b0, rem_q} > STEP) ? STEP : {1'b0, rem_q};
    sh_l   = {1'b0, work_q} << k;
    sh_r   = {work_q, 1'b0} >> k;
    sh_a   = $signed({work_q, 1'b0}) >>> k;
    rem_nx = rem_q - k[SHW-1:0];
    case (kind_q)
      SH_LSL:  begin sh_res = sh_l[WIDTH-1:0]; sh_c = sh_l[WIDTH]; end
      SH_LSR:  begin sh_res = sh_r[WIDTH:1];   sh_c = sh_r[0];     end
      SH_ASR:  begin sh_res = sh_a[WIDTH:1];   sh_c = sh_a[0];     end
      default: begin sh_res = work_q;          sh_c = 1'b0;        end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    work_d      = work_q;
    rem_d       = rem_q;
    out_d       = out_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_d       = '0;
      status_d    = '0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (n != '0)) begin
            work_d  = a_c;
            rem_d   = n;
            kind_d  = shkind_t'(fs[3:2]);
            state_d = SHIFT;
          end else begin
            out_d       = res;
            status_d    = {res_v, res_c, res[WIDTH-1], res == '0};
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = sh_res;
        rem_d  = rem_nx;
        if (rem_nx == '0) begin
          out_d       = sh_res;
          status_d    = {1'b0, sh_c, sh_res[WIDTH-1], sh_res == '0};
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= SH_LSL;
      work_q      <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: one instance with SHIFT_STEP=1, one with
// SHIFT_STEP=8; sel8 routes the handshake to the instance under test.
module tb_alu_seq;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel8, in_valid, out_ready, c0;
  logic [W-1:0] dataA, dataB;
  logic [4:0] fs;
  logic iv1, iv8, or1, or8, ir1, ir8, ov1, ov8, b1, b8;
  logic [W-1:0] o1, o8;
  logic [3:0] s1, s8;
  logic ir_m, ov_m, busy_m;
  logic [W-1:0] out_m;
  logic [3:0] st_m;

  assign iv1    = in_valid & ~sel8;
  assign iv8    = in_valid & sel8;
  assign or1    = sel8 ? 1'b1 : out_ready;
  assign or8    = sel8 ? out_ready : 1'b1;
  assign ir_m   = sel8 ? ir8 : ir1;
  assign ov_m   = sel8 ? ov8 : ov1;
  assign busy_m = sel8 ? b8 : b1;
  assign out_m  = sel8 ? o8 : o1;
  assign st_m   = sel8 ? s8 : s1;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .dataA(dataA), .dataB(dataB),
    .fs(fs), .c0(c0), .out_valid(ov1), .out_ready(or1), .out(o1), .status(s1), .busy(b1));
  alu_seq #(.WIDTH(W), .SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .dataA(dataA), .dataB(dataB),
    .fs(fs), .c0(c0), .out_valid(ov8), .out_ready(or8), .out(o8), .status(s8), .busy(b8));

  typedef struct {logic [W-1:0] o; logic [3:0] s;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] f, input logic ci);
    exp_t e;
    logic [W-1:0] x, y;
    logic [W:0] sum;
    logic c, v;
    int n;
    x = f[1] ? ~a : a;
    y = f[0] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    n = int'(b[5:0]);
    case (f[4:2])
      3'd0: e.o = x & y;
      3'd1: e.o = x | y;
      3'd2: begin
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.o = sum[W-1:0];
        c   = sum[W];
        v   = (x[W-1] == y[W-1]) && (e.o[W-1] != x[W-1]);
      end
      3'd3: e.o = x ^ y;
      3'd4, 3'd5, 3'd6: begin
        e.o = x;
        for (int i = 0; i < n; i++) begin
          if (f[4:2] == 3'd4) begin
            c = e.o[W-1];
            e.o = {e.o[W-2:0], 1'b0};
          end else begin
            c = e.o[0];
            e.o = {(f[4:2] == 3'd6) & e.o[W-1], e.o[W-1:1]};
          end
        end
      end
      default: e.o = '0;
    endcase
    e.s = {v, c, e.o[W-1], e.o == '0};
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] f,
                      input logic ci, output int waited);
    dataA = a; dataB = b; fs = f; c0 = ci; in_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!ir_m && waited < 300) begin waited++; @(negedge clk); end
    total++;
    if (!ir_m) begin bad++; $display("FAIL accept: in_ready=%b required=1", ir_m); end
    else sb.push_back(model(a, b, f, ci));
    @(posedge clk); #1;
    in_valid = 1'b0;
    dataA = {$urandom, $urandom}; dataB = {$urandom, $urandom};
    fs = 5'($urandom); c0 = 1'($urandom);
  endtask

  task automatic wait_out(output logic [W-1:0] o, output logic [3:0] s, output int busy_n,
                          output int ir_busy, output int cyc, output bit ok);
    busy_n = 0; ir_busy = 0; cyc = 0;
    @(negedge clk);
    while (!ov_m && cyc < 300) begin
      if (busy_m) busy_n++;
      if (busy_m && ir_m) ir_busy++;
      cyc++;
      @(negedge clk);
    end
    ok = ov_m; o = out_m; s = st_m;
    @(posedge clk); #1;
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '{o: '0, s: '0};
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (ov_m !== 1'b0)   begin bad++; $display("FAIL rst_valid: got=%b exp=0", ov_m); end
    if (out_m !== '0)    begin bad++; $display("FAIL rst_out: got=%h exp=0", out_m); end
    if (st_m !== 4'h0)   begin bad++; $display("FAIL rst_status: got=%h exp=0", st_m); end
    if (busy_m !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b exp=0", busy_m); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ir_m !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got=%b exp=1", ir_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [8] = '{64'd21, 64'd10, 64'd21, 64'b10101, 64'h7FFF_FFFF_FFFF_FFFF,
                             64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0000_0001};
    logic [W-1:0] tb_ [8] = '{64'd10, 64'd21, 64'd10, 64'b01010, 64'd1,
                              64'h00FF_00FF_00FF_00FF, 64'h0FF0_0FF0_0FF0_0FF0, 64'h5};
    logic [4:0] tf [8] = '{5'b01000, 5'b01001, 5'b01001, 5'b00000, 5'b01000, 5'b01110, 5'b00111, 5'b11100};
    logic tc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] o; logic [3:0] s; int bn, irb, cyc, w; bit ok; exp_t e;
    sel8 = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(ta[i], tb_[i], tf[i], tc[i], w);
      wait_out(o, s, bn, irb, cyc, ok);
      e = pop_exp();
      total += 4;
      if (!ok)       begin bad++; $display("FAIL arith%0d_timeout: out_valid=0 exp=1", i); end
      if (cyc != 0)  begin bad++; $display("FAIL arith%0d_latency: got=%0d exp=0", i, cyc); end
      if (o !== e.o) begin bad++; $display("FAIL arith%0d_out: got=%h exp=%h", i, o, e.o); end
      if (s !== e.s) begin bad++; $display("FAIL arith%0d_status: got=%b exp=%b", i, s, e.s); end
    end
  endtask

  task automatic test_shift(input bit use8);
    logic [W-1:0] ta [6] = '{64'd1, 64'b10101, 64'h8000_0000_0000_0000, 64'hF0,
                             64'h0123_4567_89AB_CDEF, 64'hC000_0000_0000_0000};
    logic [W-1:0] tb_ [6] = '{64'd63, 64'd2, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FF0D, 64'd2};
    logic [4:0] tf [6] = '{5'b10000, 5'b10100, 5'b11000, 5'b10000, 5'b10111, 5'b10000};
    logic [W-1:0] o; logic [3:0] s; int bn, irb, cyc, w, step, n, exp_b; bit ok; exp_t e;
    sel8 = use8; out_ready = 1'b1;
    step = use8 ? 8 : 1;
    for (int i = 0; i < 6; i++) begin
      n = int'(tb_[i] & 64'h3F);
      exp_b = (n + step - 1) / step;
      send(ta[i], tb_[i], tf[i], 1'b0, w);
      wait_out(o, s, bn, irb, cyc, ok);
      e = pop_exp();
      total += 5;
      if (!ok)          begin bad++; $display("FAIL sh%0d_%0d_timeout: out_valid=0 exp=1", step, i); end
      if (bn != exp_b)  begin bad++; $display("FAIL sh%0d_%0d_busy: got=%0d exp=%0d", step, i, bn, exp_b); end
      if (irb != 0)     begin bad++; $display("FAIL sh%0d_%0d_in_ready: got=%0d exp=0", step, i, irb); end
      if (o !== e.o)    begin bad++; $display("FAIL sh%0d_%0d_out: got=%h exp=%h", step, i, o, e.o); end
      if (s !== e.s)    begin bad++; $display("FAIL sh%0d_%0d_status: got=%b exp=%b", step, i, s, e.s); end
    end
    sel8 = 1'b0;
  endtask

  task automatic test_backpressure();
    int w; exp_t e;
    sel8 = 1'b0; out_ready = 1'b0;
    send(64'd100, 64'd23, 5'b01000, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total += 3;
      if (ov_m !== 1'b1)     begin bad++; $display("FAIL bp%0d_valid: got=%b exp=1", i, ov_m); end
      if (ir_m !== 1'b0)     begin bad++; $display("FAIL bp%0d_in_ready: got=%b exp=0", i, ir_m); end
      if (out_m !== sb[0].o) begin bad++; $display("FAIL bp%0d_out: got=%h exp=%h", i, out_m, sb[0].o); end
      @(posedge clk); #1;
    end
    void'(pop_exp());
    out_ready = 1'b1;
    send(64'hFFFF_0000_FFFF_0000, 64'h00FF_00FF_00FF_00FF, 5'b01100, 1'b0, w);
    e = pop_exp();
    total += 4;
    if (w != 0)        begin bad++; $display("FAIL bp_accept_wait: got=%0d exp=0", w); end
    if (ov_m !== 1'b1) begin bad++; $display("FAIL bp_nogap_valid: got=%b exp=1", ov_m); end
    if (out_m !== e.o) begin bad++; $display("FAIL bp_nogap_out: got=%h exp=%h", out_m, e.o); end
    if (st_m !== e.s)  begin bad++; $display("FAIL bp_nogap_status: got=%b exp=%b", st_m, e.s); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w; exp_t e;
    sel8 = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 15)), 1'($urandom), w);
      e = pop_exp();
      total += 3;
      if (w != 0)        begin bad++; $display("FAIL b2b%0d_wait: got=%0d exp=0", i, w); end
      if (ov_m !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid: got=%b exp=1", i, ov_m); end
      if ({out_m, st_m} !== {e.o, e.s})
        begin bad++; $display("FAIL b2b%0d_result: got=%h/%b exp=%h/%b", i, out_m, st_m, e.o, e.s); end
    end
    @(posedge clk); #1;
    total++;
    if (ov_m !== 1'b0) begin bad++; $display("FAIL b2b_drain: out_valid=%b exp=0", ov_m); end
  endtask

  task automatic test_reset_mid_shift();
    int w, seen;
    sel8 = 1'b0; out_ready = 1'b1;
    send(64'd1, 64'd40, 5'b10000, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    total++;
    if (busy_m !== 1'b1) begin bad++; $display("FAIL rms_busy_before: got=%b exp=1", busy_m); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(sb.pop_back());
    total += 4;
    if (ov_m !== 1'b0)   begin bad++; $display("FAIL rms_valid: got=%b exp=0", ov_m); end
    if (busy_m !== 1'b0) begin bad++; $display("FAIL rms_busy: got=%b exp=0", busy_m); end
    if (ir_m !== 1'b1)   begin bad++; $display("FAIL rms_in_ready: got=%b exp=1", ir_m); end
    if (out_m !== '0)    begin bad++; $display("FAIL rms_out: got=%h exp=0", out_m); end
    seen = 0;
    repeat (60) begin @(negedge clk); if (ov_m) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rms_stale: valid_cycles=%0d exp=0", seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sel8 = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dataA = '0; dataB = '0; fs = '0; c0 = 1'b0;
    test_reset();
    test_arith();
    test_shift(1'b0);
    test_shift(1'b1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
